// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter: parallel-to-serial stage for the serial-in shift register.
// A word taken over valid/ready comes out one bit per clock on x_o. Back-to-back
// words need no idle gap, because the next word can be taken during the last-bit cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no word in flight; ready_o=1, all serial outputs low
//   SHIFT | word in flight; x_o is valid; ready_o=1 only on the last bit
module serial_tx_shifter #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              x_o,
  output logic              bit_valid_o,
  output logic              last_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              is_last;
  logic              accept;
  logic              out_bit;

  assign is_last = (state == SHIFT) && (cnt == CNT_LAST);
  assign accept  = valid_i && ready_o;
  assign out_bit = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a valid word on the last bit keeps the stream in SHIFT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = SHIFT;
      SHIFT:   if (is_last && !valid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come from registered state only, so there is no input-to-output path.
  always_comb begin
    ready_o     = 1'b1;
    x_o         = 1'b0;
    bit_valid_o = 1'b0;
    last_o      = 1'b0;
    busy_o      = 1'b0;
    if (state == SHIFT) begin
      ready_o     = is_last;
      x_o         = out_bit;
      bit_valid_o = 1'b1;
      last_o      = is_last;
      busy_o      = 1'b1;
    end
  end

  // Datapath: load on accept, otherwise shift toward the output end.
  // The counter is cleared on the last bit rather than wrapped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= data_i;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      if (is_last) begin
        shreg <= '0;
        cnt   <= '0;
      end else begin
        shreg <= MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter. Two instances are used: one sends MSB first and one
// sends LSB first. Most checks come from a vector table; reset cases are written out.
module tb_serial_tx_shifter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data_m = 4'h0, data_l = 4'h0;
  logic       valid_m = 1'b0, valid_l = 1'b0;
  logic       m_ready, m_x, m_bv, m_last, m_busy;
  logic       l_ready, l_x, l_bv, l_last, l_busy;
  logic [3:0] ds = 4'h0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_tx_shifter #(.DATA_W(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_i(data_m), .valid_i(valid_m),
    .ready_o(m_ready), .x_o(m_x), .bit_valid_o(m_bv), .last_o(m_last), .busy_o(m_busy)
  );

  serial_tx_shifter #(.DATA_W(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_i(data_l), .valid_i(valid_l),
    .ready_o(l_ready), .x_o(l_x), .bit_valid_o(l_bv), .last_o(l_last), .busy_o(l_busy)
  );

  // Downstream 4-bit left-shifting serial-in register fed by the MSB-first instance.
  always @(posedge clk) if (m_bv) ds <= {ds[2:0], m_x};

  typedef struct {
    bit       lsb;
    bit       v;
    bit [3:0] d;
    bit       x, bv, last, rdy, busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_m(input string tag, input int idx, input bit x, input bit bv,
                       input bit last, input bit rdy, input bit busy);
    chk({tag, "_x"}, idx, {3'b0, m_x}, {3'b0, x});
    chk({tag, "_bv"}, idx, {3'b0, m_bv}, {3'b0, bv});
    chk({tag, "_last"}, idx, {3'b0, m_last}, {3'b0, last});
    chk({tag, "_ready"}, idx, {3'b0, m_ready}, {3'b0, rdy});
    chk({tag, "_busy"}, idx, {3'b0, m_busy}, {3'b0, busy});
  endtask

  function automatic void add(bit lsb, bit v, bit [3:0] d, bit x, bit bv, bit last, bit rdy, bit busy);
    vec_t t;
    t.lsb = lsb; t.v = v; t.d = d;
    t.x = x; t.bv = bv; t.last = last; t.rdy = rdy; t.busy = busy;
    vecs.push_back(t);
  endfunction

  initial begin
    // Each entry gives the inputs driven before an edge and the outputs expected after it.
    // Single word 1011, MSB first.
    add(0, 1, 4'b1011, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0,    0, 1, 0, 0, 1);
    add(0, 0, 4'h0,    1, 1, 0, 0, 1);
    add(0, 0, 4'h0,    1, 1, 1, 1, 1);
    add(0, 0, 4'h0,    0, 0, 0, 1, 0);
    // Back-to-back: A, then 5 taken on A's last bit.
    add(0, 1, 4'hA,    1, 1, 0, 0, 1);
    add(0, 0, 4'h0,    0, 1, 0, 0, 1);
    add(0, 0, 4'h0,    1, 1, 0, 0, 1);
    add(0, 0, 4'h0,    0, 1, 1, 1, 1);
    add(0, 1, 4'h5,    0, 1, 0, 0, 1);
    add(0, 0, 4'h0,    1, 1, 0, 0, 1);
    add(0, 0, 4'h0,    0, 1, 0, 0, 1);
    add(0, 0, 4'h0,    1, 1, 1, 1, 1);
    add(0, 0, 4'h0,    0, 0, 0, 1, 0);
    // Not-ready: 3 is offered during bit 1 of C and must be ignored.
    add(0, 1, 4'hC,    1, 1, 0, 0, 1);
    add(0, 0, 4'h0,    1, 1, 0, 0, 1);
    add(0, 1, 4'h3,    0, 1, 0, 0, 1);
    add(0, 0, 4'h0,    0, 1, 1, 1, 1);
    add(0, 0, 4'h0,    0, 0, 0, 1, 0);
    add(0, 0, 4'h0,    0, 0, 0, 1, 0);
    // LSB first, 1000.
    add(1, 1, 4'b1000, 0, 1, 0, 0, 1);
    add(1, 0, 4'h0,    0, 1, 0, 0, 1);
    add(1, 0, 4'h0,    0, 1, 0, 0, 1);
    add(1, 0, 4'h0,    1, 1, 1, 1, 1);
    add(1, 0, 4'h0,    0, 0, 0, 1, 0);

    // Reset held for 3 edges with a word offered.
    valid_m = 1'b1; data_m = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_m("rst", c, 0, 0, 0, 1, 0);
    end
    reset = 1'b1;
    valid_m = 1'b0; data_m = 4'h0;
    @(posedge clk); #1;
    chk_m("post_rst", 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      valid_m = vecs[i].lsb ? 1'b0 : vecs[i].v;
      data_m  = vecs[i].lsb ? 4'h0 : vecs[i].d;
      valid_l = vecs[i].lsb ? vecs[i].v : 1'b0;
      data_l  = vecs[i].lsb ? vecs[i].d : 4'h0;
      @(posedge clk); #1;
      if (vecs[i].lsb) begin
        chk("vec_x", i, {3'b0, l_x}, {3'b0, vecs[i].x});
        chk("vec_bv", i, {3'b0, l_bv}, {3'b0, vecs[i].bv});
        chk("vec_last", i, {3'b0, l_last}, {3'b0, vecs[i].last});
        chk("vec_ready", i, {3'b0, l_ready}, {3'b0, vecs[i].rdy});
        chk("vec_busy", i, {3'b0, l_busy}, {3'b0, vecs[i].busy});
      end else begin
        chk_m("vec", i, vecs[i].x, vecs[i].bv, vecs[i].last, vecs[i].rdy, vecs[i].busy);
      end
      if (i == 4) chk("downstream_word", i, ds, 4'b1011);
    end
    valid_m = 1'b0; valid_l = 1'b0;

    // Reset in the middle of a word: F is dropped during bit 2.
    valid_m = 1'b1; data_m = 4'hF;
    @(posedge clk); #1;
    valid_m = 1'b0; data_m = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_m("pre_abort", 2, 1, 1, 0, 0, 1);
    #2 reset = 1'b0;
    #1 chk_m("async_abort", 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk_m("abort_hold", 0, 0, 0, 0, 1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_m("abort_release", 0, 0, 0, 0, 1, 0);

    // After release, 9 must come out as 1,0,0,1.
    valid_m = 1'b1; data_m = 4'h9;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      valid_m = 1'b0; data_m = 4'h0;
      chk_m("after_abort", k, (k == 0 || k == 3), 1, (k == 3), (k == 3), 1);
    end
    @(posedge clk); #1;
    chk_m("after_abort_idle", 4, 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
- Parallel-to-serial stage that feeds the team's serial-in shift register.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits it one bit per clock on x_o.
- Flags each emitted bit and the final bit of each word.
- Supports back-to-back words with no idle gap, so the downstream shift register sees a continuous bit stream.

Parameters:
DATA_W, 4, word width in bits; legal range DATA_W >= 2.
MSB_FIRST, 1, 1 = emit bit DATA_W-1 first; 0 = emit bit 0 first.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clk.
data_i  input  DATA_W  parallel word to serialize.
valid_i  input  1  data_i is valid.
ready_o  output  1  block can accept a word this cycle.
x_o  output  1  serial data bit.
bit_valid_o  output  1  x_o carries a real bit this cycle.
last_o  output  1  x_o is the final bit of the current word.
busy_o  output  1  a word is in flight (SHIFT state).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; shift register and bit counter clear to 0.
  - Outputs: x_o=0, bit_valid_o=0, last_o=0, busy_o=0, ready_o=1 (ready_o is combinational from state).
- States:
  - IDLE: ready_o=1, bit_valid_o=0, x_o=0, last_o=0, busy_o=0.
  - SHIFT: bit_valid_o=1, busy_o=1.
- Accept: a word is accepted on a rising edge where valid_i=1 and ready_o=1.
  - data_i loads into the internal shift register.
  - Bit counter clears to 0; state goes to SHIFT.
- Output bit selection in SHIFT:
  - x_o = shreg[DATA_W-1] when MSB_FIRST=1, else shreg[0].
  - x_o is driven directly from the register, so no combinational path from inputs.
- Each edge in SHIFT:
  - Shift register shifts by one toward the output end; a 0 fills the vacated bit.
  - Counter increments.
- Last bit:
  - last_o=1 when counter == DATA_W-1 in SHIFT.
  - ready_o=1 in SHIFT only during that last-bit cycle.
  - Counter width is $clog2(DATA_W); the counter never wraps past DATA_W-1.
- End of word: on the last-bit edge,
  - If valid_i=1: load the new word, counter to 0, stay in SHIFT (zero-gap back-to-back).
  - Else: go to IDLE.
- Latency:
  - Word accepted at edge N; bit k is on x_o from edge N+k to edge N+k+1, for k = 0..DATA_W-1.
  - Exactly DATA_W bit_valid_o cycles per word.
- Downstream alignment: with MSB_FIRST=1 and DATA_W=4, a downstream 4-bit left-shifting serial-in register holds the original word after the last-bit edge.
- Not-ready cycles: valid_i=1 while ready_o=0 is ignored, and data_i is not sampled. The source must hold the word until the handshake completes.
- Input changes: data_i changes during SHIFT have no effect on the word in flight.
- Reset mid-word: the word is abandoned immediately with no further bits. After reset release, the block returns to IDLE with ready_o=1.
- Rejected: valid_i is X/irrelevant when ready_o=0; no error flag.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with valid_i=1, data_i=4'hF -> x_o=0, bit_valid_o=0, busy_o=0, ready_o=1 throughout.
2. Single word: DATA_W=4, MSB_FIRST=1, data_i=4'b1011 accepted at edge N ->
   - x_o = 1,0,1,1 on cycles N..N+3; bit_valid_o=1 for 4 cycles; last_o=1 only on cycle N+3.
   - IDLE at N+4; downstream 4-bit shift register holds 4'b1011.
3. Back-to-back: 4'hA, then 4'h5 presented with valid_i held on the last-bit cycle ->
   - x_o = 1,0,1,0,0,1,0,1 over 8 consecutive cycles, bit_valid_o never drops.
   - ready_o=1 only in cycles 4 and 8 of the stream.
4. LSB first: MSB_FIRST=0, data_i=4'b1000 -> x_o = 0,0,0,1, last_o on the 4th bit.
5. Not-ready ignore: during SHIFT of 4'hC, drive valid_i=1 with data_i=4'h3 on bit 1 only ->
   - Stream is exactly 1,1,0,0; block returns to IDLE; 4'h3 is never emitted.
6. Reset mid-word: assert reset=0 asynchronously after bit 2 of 4'hF ->
   - x_o, bit_valid_o, busy_o go 0 without waiting for clk.
   - After release, a new word 4'h9 serializes as 1,0,0,1.
